// File: rtl/dmem_io_arbiter.sv
// Shares the single-port data RAM and the IO bus between the CPU load/store path
// and the UART program loader with a fixed 3-cycle IDLE/ISSUE/RESP access sequence.
module dmem_io_arbiter #(
    parameter logic [31:0] IO_BASE      = 32'hFFFF_FC00,
    parameter int unsigned IO_SPAN_LOG2 = 10,
    parameter int unsigned IO_W         = 16,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cpu_req_i,
    input  logic            cpu_we_i,
    input  logic [31:0]     cpu_addr_i,
    input  logic [31:0]     cpu_wdata_i,
    output logic [31:0]     cpu_rdata_o,
    output logic            cpu_ack_o,
    output logic            cpu_stall_o,
    input  logic            uart_req_i,
    input  logic [31:0]     uart_addr_i,
    input  logic [31:0]     uart_wdata_i,
    output logic            uart_ack_o,
    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [31:0]     mem_addr_o,
    output logic [31:0]     mem_wdata_o,
    input  logic [31:0]     mem_rdata_i,
    output logic            io_rd_o,
    output logic            io_wr_o,
    output logic [31:0]     io_addr_o,
    output logic [31:0]     io_wdata_o,
    input  logic [IO_W-1:0] io_rdata_i
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;
    typedef enum logic {OWN_CPU, OWN_UART} owner_e;

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    logic            we_q, we_d;
    logic            io_q, io_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic            io_rd_q, io_rd_d, io_wr_q, io_wr_d;
    logic            cpu_ack_q, cpu_ack_d, uart_ack_q, uart_ack_d;
    logic [31:0]     mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [31:0]     io_addr_q, io_addr_d, io_wdata_q, io_wdata_d;
    logic [IO_W-1:0] io_rdata_q, io_rdata_d;

    logic cpu_io_hit;
    logic uart_wins;

    assign cpu_io_hit = (cpu_addr_i[31:IO_SPAN_LOG2] == IO_BASE[31:IO_SPAN_LOG2]);
    // A starved CPU blocks the UART only while it is actually requesting.
    assign uart_wins  = uart_req_i && !(cpu_req_i && (starve_q >= STARVE_MAX));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        io_d        = io_q;
        starve_d    = cpu_req_i ? starve_q : '0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        io_rd_d     = 1'b0;
        io_wr_d     = 1'b0;
        cpu_ack_d   = 1'b0;
        uart_ack_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        io_addr_d   = io_addr_q;
        io_wdata_d  = io_wdata_q;
        io_rdata_d  = io_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (uart_wins) begin
                    owner_d     = OWN_UART;
                    we_d        = 1'b1;
                    io_d        = 1'b0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = uart_addr_i;
                    mem_wdata_d = uart_wdata_i;
                    state_d     = S_ISSUE;
                    if (cpu_req_i) begin
                        starve_d = (starve_q >= STARVE_MAX) ? STARVE_MAX : starve_q + SW'(1);
                    end
                end else if (cpu_req_i) begin
                    owner_d  = OWN_CPU;
                    we_d     = cpu_we_i;
                    io_d     = cpu_io_hit;
                    starve_d = '0;
                    state_d  = S_ISSUE;
                    if (cpu_io_hit) begin
                        io_rd_d    = !cpu_we_i;
                        io_wr_d    = cpu_we_i;
                        io_addr_d  = cpu_addr_i;
                        io_wdata_d = cpu_wdata_i;
                    end else begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = cpu_we_i;
                        mem_addr_d  = cpu_addr_i;
                        mem_wdata_d = cpu_wdata_i;
                    end
                end
            end
            S_ISSUE: begin
                if (io_rd_q) begin
                    io_rdata_d = io_rdata_i;
                end
                cpu_ack_d  = (owner_q == OWN_CPU);
                uart_ack_d = (owner_q == OWN_UART);
                state_d    = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            io_q        <= 1'b0;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            io_rd_q     <= 1'b0;
            io_wr_q     <= 1'b0;
            cpu_ack_q   <= 1'b0;
            uart_ack_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            io_addr_q   <= '0;
            io_wdata_q  <= '0;
            io_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            io_q        <= io_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            io_rd_q     <= io_rd_d;
            io_wr_q     <= io_wr_d;
            cpu_ack_q   <= cpu_ack_d;
            uart_ack_q  <= uart_ack_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            io_addr_q   <= io_addr_d;
            io_wdata_q  <= io_wdata_d;
            io_rdata_q  <= io_rdata_d;
        end
    end

    // Load data is only driven during the ack cycle; RAM data arrives straight from the RAM port.
    assign cpu_rdata_o = (cpu_ack_q && !we_q) ? (io_q ? 32'(io_rdata_q) : mem_rdata_i) : '0;
    assign cpu_ack_o   = cpu_ack_q;
    assign cpu_stall_o = cpu_req_i && !cpu_ack_q;
    assign uart_ack_o  = uart_ack_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign io_rd_o     = io_rd_q;
    assign io_wr_o     = io_wr_q;
    assign io_addr_o   = io_addr_q;
    assign io_wdata_o  = io_wdata_q;

endmodule
